mmio_port_responder: RTL and testbench
======================================

// Module: mmio_port_responder
// PURPOSE
// Memory-mapped I/O responder on the slave side of the processor's data-bus load/store path.
// Decodes a small register window and services single-word accesses with a Req/Ack handshake and
// programmable wait states. Drives the PortOut register, presents a synchronised PortIn, and flags input changes.
// Sits beside data RAM; the core's address decode routes matching lw/sw accesses here.
// PARAMETERS
// BASE_ADDR    32'h1001_0000  base of 16-byte window; bits [3:0] must be 0
// WAIT_CYCLES  2              wait states between request accept and Ack (0..15)
// IN_WIDTH     8              width of PortIn
// PORTS
// clk        in   1         system clock, rising edge
// reset      in   1         asynchronous, active-high reset
// Req        in   1         access request; held high until Ack
// WriteEn    in   1         1=store (sw), 0=load (lw); sampled on accept
// Address    in   32        byte address; sampled on accept
// WriteData  in   32        store data; sampled on accept
// Hit        out  1         comb: Address[31:4]==BASE_ADDR[31:4] && Address[1:0]==0
// Ack        out  1         one-cycle pulse: access complete
// ReadData   out  32        load data; valid in Ack cycle, held until next Ack
// PortIn     in   IN_WIDTH  asynchronous external input
// PortOut    out  32        output port register
// InChanged  out  1         sticky flag: synchronised PortIn changed
// BEHAVIOUR
// Register map (offset = Address[3:2]):
//  0 PORT_OUT  R/W
//  1 PORT_IN   RO, zero-extended synchronised input; writes ignored but acked
//  2 STATUS    bit0=InChanged, other bits read 0; writing 1 to bit0 clears it (W1C)
//  3 reserved  reads 0; writes ignored but acked
// Reset (async): state=IDLE, wait counter=0, Ack=0, ReadData=0, PortOut=0, sync stages=0, InChanged=0.
// FSM:
//  IDLE: Req&&Hit -> latch WriteEn/Address[3:2]/WriteData; load counter=WAIT_CYCLES.
//        Go to WAIT, or to RESP if WAIT_CYCLES==0.
//        Req&&!Hit -> stay IDLE; never Ack.
//  WAIT: counter decrements each cycle; RESP when counter reaches 1 -> 0.
//        Req low while in WAIT -> abort to IDLE: no write, no Ack, ReadData unchanged.
//  RESP: Ack=1 for exactly this cycle; write committed on this edge; ReadData registered.
//        Next state always IDLE.
//        A new request is accepted no earlier than the cycle after RESP (min 1 idle cycle).
// Latency: Req first high in IDLE at cycle 0 -> Ack high in cycle WAIT_CYCLES+1.
// Req/WriteEn/Address/WriteData changes after accept do not affect the in-flight access.
// Input path:
//  - 2-flop synchroniser on PortIn; 3rd register holds the previous synchronised value.
//  - InChanged sets on any cycle where sync2 != prev.
//  - Set and W1C clear in the same cycle -> set wins, flag stays 1.
// PORT_IN read returns the sync2 value at the RESP edge.
// Reset mid-access: immediate return to IDLE, Ack low, pending write discarded.
// TESTING
// T1 reset; sw 0xDEADBEEF @BASE+0, WAIT_CYCLES=2 -> Ack in cycle 3 only; PortOut=0xDEADBEEF after that edge; lw @BASE+0 -> ReadData=0xDEADBEEF
// T2 PortIn 0x00->0xA5; lw @BASE+4 after 3 cycles -> ReadData=0x000000A5; lw @BASE+8 -> 0x1; sw 0x1 @BASE+8 -> subsequent lw -> 0x0
// T3 Req @0x1000_0000 (miss) held 10 cycles -> Hit=0, Ack never 1, PortOut unchanged
// T4 sw 0x55 @BASE+0, Req dropped in WAIT cycle 1 -> no Ack; PortOut keeps old value; next sw completes normally
// T5 PortIn toggles on the same edge as W1C to STATUS -> InChanged reads 1 afterwards
// T6 WAIT_CYCLES=0 build: back-to-back sw then lw -> Ack in cycle 1 of each, one idle cycle between; reset asserted during WAIT -> Ack 0, PortOut=0

Source files
------------

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder: a 16-byte register window served over a Req/Ack
// handshake with programmable wait states, an output port register and a synchronised input port.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          WAIT_CYCLES = 2,
  parameter int          IN_WIDTH    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Req,
  input  logic                WriteEn,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  output logic                Hit,
  output logic                Ack,
  output logic [31:0]         ReadData,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                InChanged,
  output logic [1:0]          StateDbg
);

  // Handshake: the master raises Req with WriteEn/Address/WriteData and holds Req
  // high until it sees the one-cycle Ack pulse; the access fields are captured on
  // accept, so they may change afterwards. Dropping Req before Ack aborts the access.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t              state;
  logic [3:0]          waitCnt;
  logic                latWrite;
  logic [1:0]          latOff;
  logic [31:0]         latData;
  logic [IN_WIDTH-1:0] sync1;
  logic [IN_WIDTH-1:0] sync2;
  logic [IN_WIDTH-1:0] prevIn;

  logic        accept;
  logic        commit;
  logic        accWrite;
  logic [1:0]  accOff;
  logic [31:0] accData;
  logic        inSet;
  logic        statusClear;

  always_comb begin
    Hit    = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00);
    accept = (state == S_IDLE) && Req && Hit;
    // With no wait states the access commits on the accept edge, straight from the bus.
    commit = (ZERO_WAIT && accept) ||
             ((state == S_WAIT) && Req && (waitCnt == 4'd1));
    if (state == S_IDLE) begin
      accWrite = WriteEn;
      accOff   = Address[3:2];
      accData  = WriteData;
    end else begin
      accWrite = latWrite;
      accOff   = latOff;
      accData  = latData;
    end
    inSet       = (sync2 != prevIn);
    statusClear = commit && accWrite && (accOff == 2'd2) && accData[0];
    StateDbg    = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      waitCnt  <= 4'd0;
      Ack      <= 1'b0;
      latWrite <= 1'b0;
      latOff   <= 2'd0;
      latData  <= 32'd0;
    end else begin
      Ack <= commit;
      case (state)
        S_IDLE: begin
          if (accept) begin
            latWrite <= WriteEn;
            latOff   <= Address[3:2];
            latData  <= WriteData;
            waitCnt  <= WAIT_LOAD;
            state    <= ZERO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!Req) begin
            waitCnt <= 4'd0;
            state   <= S_IDLE;
          end else begin
            waitCnt <= waitCnt - 4'd1;
            if (waitCnt == 4'd1) state <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath: the port register, load data and the input change detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      prevIn    <= '0;
      InChanged <= 1'b0;
      PortOut   <= 32'd0;
      ReadData  <= 32'd0;
    end else begin
      sync1     <= PortIn;
      sync2     <= sync1;
      prevIn    <= sync2;
      InChanged <= inSet || (InChanged && !statusClear);
      if (commit) begin
        if (accWrite) begin
          if (accOff == 2'd0) PortOut <= accData;
        end else begin
          case (accOff)
            2'd0:    ReadData <= PortOut;
            2'd1:    ReadData <= 32'(sync2);
            2'd2:    ReadData <= {31'd0, InChanged};
            default: ReadData <= 32'd0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: one instance with two wait states, one with none,
// driven by directed and randomized accesses against a register-level model.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int WAIT_A = 2;
  localparam int WAIT_B = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        reqA = 0, weA = 0, hitA, ackA, chgA;
  logic [31:0] addrA = 0, wdA = 0, rdA, poutA;
  logic [7:0]  pinA = 0;
  logic [1:0]  dbgA;

  logic        reqB = 0, weB = 0, hitB, ackB, chgB;
  logic [31:0] addrB = 0, wdB = 0, rdB, poutB;
  logic [7:0]  pinB = 0;
  logic [1:0]  dbgB;

  int tests_run = 0;
  int tests_failed = 0;

  // Register-level model, index 0 = instance A, 1 = instance B.
  logic [31:0] mPort[2];
  logic        mChg[2];
  logic [31:0] mPin[2];
  logic [31:0] mRd[2];

  mmio_port_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAIT_A), .IN_WIDTH(8)) dutA (
    .clk(clk), .reset(reset), .Req(reqA), .WriteEn(weA), .Address(addrA),
    .WriteData(wdA), .Hit(hitA), .Ack(ackA), .ReadData(rdA), .PortIn(pinA),
    .PortOut(poutA), .InChanged(chgA), .StateDbg(dbgA)
  );

  mmio_port_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAIT_B), .IN_WIDTH(8)) dutB (
    .clk(clk), .reset(reset), .Req(reqB), .WriteEn(weB), .Address(addrB),
    .WriteData(wdB), .Hit(hitB), .Ack(ackB), .ReadData(rdB), .PortIn(pinB),
    .PortOut(poutB), .InChanged(chgB), .StateDbg(dbgB)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic cur_ack(input bit sel);
    return sel ? ackB : ackA;
  endfunction

  function automatic logic [31:0] cur_rd(input bit sel);
    return sel ? rdB : rdA;
  endfunction

  function automatic logic [31:0] cur_pout(input bit sel);
    return sel ? poutB : poutA;
  endfunction

  function automatic int exp_lat(input bit sel);
    return (sel ? WAIT_B : WAIT_A) + 1;
  endfunction

  function automatic logic [31:0] reg_addr(input logic [1:0] off);
    return BASE | (32'(off) << 2);
  endfunction

  task automatic drive(input bit sel, input bit req, input bit we,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      reqB = req; weB = we; addrB = a; wdB = d;
    end else begin
      reqA = req; weA = we; addrA = a; wdA = d;
    end
  endtask

  // Runs one access; lat counts edges from Req assertion to the Ack cycle
  // (20 means no Ack seen). Bus fields are scrambled after accept.
  task automatic do_access(input bit sel, input bit we, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output int lat);
    bit done;
    done = 0;
    lat = 0;
    rd = '0;
    drive(sel, 1'b1, we, a, d);
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      lat++;
      if (cur_ack(sel) === 1'b1) begin
        done = 1;
        rd = cur_rd(sel);
      end else begin
        drive(sel, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
    end
    if (!done) lat = 20;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    tests_run++;
    if (cur_ack(sel) !== 1'b0) begin
      tests_failed++;
      $display("FAIL ack_pulse: Ack=%b in idle cycle after Ack, expected 0", cur_ack(sel));
    end
  endtask

  task automatic test_reset;
    tests_run++;
    if ({ackA, chgA, dbgA} !== 4'b0 || rdA !== 32'd0 || poutA !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_a: ack=%b chg=%b state=%0d rd=%h pout=%h, expected all 0",
               ackA, chgA, dbgA, rdA, poutA);
    end
    tests_run++;
    if ({ackB, chgB, dbgB} !== 4'b0 || rdB !== 32'd0 || poutB !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_b: ack=%b chg=%b state=%0d rd=%h pout=%h, expected all 0",
               ackB, chgB, dbgB, rdB, poutB);
    end
    addrA = BASE + 32'd12; #1;
    tests_run++;
    if (hitA !== 1'b1) begin
      tests_failed++; $display("FAIL hit_in_window: got %b expected 1", hitA);
    end
    addrA = BASE + 32'd6; #1;
    tests_run++;
    if (hitA !== 1'b0) begin
      tests_failed++; $display("FAIL hit_unaligned: got %b expected 0", hitA);
    end
    addrA = BASE + 32'd16; #1;
    tests_run++;
    if (hitA !== 1'b0) begin
      tests_failed++; $display("FAIL hit_above_window: got %b expected 0", hitA);
    end
    addrA = 32'd0;
  endtask

  task automatic test_write_read;
    logic [31:0] rd;
    int lat;
    do_access(0, 1'b1, BASE, 32'hDEAD_BEEF, rd, lat);
    mPort[0] = 32'hDEAD_BEEF;
    tests_run++;
    if (lat !== exp_lat(0)) begin
      tests_failed++; $display("FAIL sw_latency: got %0d expected %0d", lat, exp_lat(0));
    end
    tests_run++;
    if (poutA !== mPort[0]) begin
      tests_failed++; $display("FAIL sw_portout: got %h expected %h", poutA, mPort[0]);
    end
    do_access(0, 1'b0, BASE, 32'd0, rd, lat);
    mRd[0] = mPort[0];
    tests_run++;
    if (lat !== exp_lat(0) || rd !== mRd[0]) begin
      tests_failed++;
      $display("FAIL lw_portout: lat=%0d rd=%h expected lat=%0d rd=%h", lat, rd, exp_lat(0), mRd[0]);
    end
  endtask

  task automatic test_port_in;
    logic [31:0] rd;
    int lat;
    pinA = 8'hA5;
    mPin[0] = 32'h0000_00A5;
    mChg[0] = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    do_access(0, 1'b0, reg_addr(2'd1), 32'd0, rd, lat);
    mRd[0] = mPin[0];
    tests_run++;
    if (rd !== mRd[0]) begin
      tests_failed++; $display("FAIL lw_port_in: got %h expected %h", rd, mRd[0]);
    end
    do_access(0, 1'b0, reg_addr(2'd2), 32'd0, rd, lat);
    mRd[0] = {31'd0, mChg[0]};
    tests_run++;
    if (rd !== mRd[0]) begin
      tests_failed++; $display("FAIL lw_status_set: got %h expected %h", rd, mRd[0]);
    end
    do_access(0, 1'b1, reg_addr(2'd2), 32'd1, rd, lat);
    mChg[0] = 1'b0;
    do_access(0, 1'b0, reg_addr(2'd2), 32'd0, rd, lat);
    mRd[0] = {31'd0, mChg[0]};
    tests_run++;
    if (rd !== mRd[0] || chgA !== mChg[0]) begin
      tests_failed++;
      $display("FAIL status_w1c: rd=%h flag=%b expected rd=%h flag=%b", rd, chgA, mRd[0], mChg[0]);
    end
  endtask

  task automatic test_random_access;
    logic [31:0] rd, d, expRd;
    logic [1:0] off;
    bit sel, we;
    int lat;
    for (int n = 0; n < 24; n++) begin
      sel = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      off = 2'($urandom_range(0, 3));
      d   = $urandom;
      expRd = mRd[sel];
      if (we) begin
        if (off == 2'd0) mPort[sel] = d;
        if (off == 2'd2 && d[0]) mChg[sel] = 1'b0;
      end else begin
        case (off)
          2'd0:    expRd = mPort[sel];
          2'd1:    expRd = mPin[sel];
          2'd2:    expRd = {31'd0, mChg[sel]};
          default: expRd = 32'd0;
        endcase
        mRd[sel] = expRd;
      end
      do_access(sel, we, reg_addr(off), d, rd, lat);
      tests_run++;
      if (lat !== exp_lat(sel) || cur_pout(sel) !== mPort[sel] ||
          (!we && rd !== expRd)) begin
        tests_failed++;
        $display("FAIL random_access[%0d]: dut=%0d we=%0d off=%0d lat=%0d rd=%h pout=%h expected lat=%0d rd=%h pout=%h",
                 n, sel, we, off, lat, rd, cur_pout(sel), exp_lat(sel), expRd, mPort[sel]);
      end
    end
  endtask

  task automatic test_miss;
    drive(0, 1'b1, 1'b1, 32'h1000_0000, $urandom);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (hitA !== 1'b0 || ackA !== 1'b0) begin
        tests_failed++;
        $display("FAIL miss_cycle[%0d]: hit=%b ack=%b expected 0 0", i, hitA, ackA);
      end
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    tests_run++;
    if (poutA !== mPort[0]) begin
      tests_failed++; $display("FAIL miss_portout: got %h expected %h", poutA, mPort[0]);
    end
  endtask

  task automatic test_abort;
    logic [31:0] rd;
    int lat;
    bit sawAck;
    do_access(0, 1'b1, BASE, 32'h0BAD_F00D, rd, lat);
    mPort[0] = 32'h0BAD_F00D;
    drive(0, 1'b1, 1'b1, BASE, 32'h55);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    sawAck = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ackA === 1'b1) sawAck = 1;
    end
    tests_run++;
    if (sawAck || poutA !== mPort[0] || rdA !== mRd[0]) begin
      tests_failed++;
      $display("FAIL abort: ack_seen=%0d pout=%h rd=%h expected 0 %h %h",
               sawAck, poutA, rdA, mPort[0], mRd[0]);
    end
    do_access(0, 1'b1, BASE, 32'h55, rd, lat);
    mPort[0] = 32'h55;
    tests_run++;
    if (lat !== exp_lat(0) || poutA !== mPort[0]) begin
      tests_failed++;
      $display("FAIL after_abort_sw: lat=%0d pout=%h expected %0d %h", lat, poutA, exp_lat(0), mPort[0]);
    end
  endtask

  task automatic test_set_wins;
    logic [31:0] rd;
    int lat;
    // The toggle reaches the change detector on the same edge the W1C commits.
    pinA = ~pinA;
    mPin[0] = 32'(pinA);
    do_access(0, 1'b1, reg_addr(2'd2), 32'd1, rd, lat);
    mChg[0] = 1'b1;
    tests_run++;
    if (chgA !== mChg[0]) begin
      tests_failed++; $display("FAIL set_wins_flag: got %b expected %b", chgA, mChg[0]);
    end
    do_access(0, 1'b0, reg_addr(2'd2), 32'd0, rd, lat);
    mRd[0] = {31'd0, mChg[0]};
    tests_run++;
    if (rd !== mRd[0]) begin
      tests_failed++; $display("FAIL set_wins_read: got %h expected %h", rd, mRd[0]);
    end
    do_access(0, 1'b1, reg_addr(2'd2), 32'd1, rd, lat);
    mChg[0] = 1'b0;
    tests_run++;
    if (chgA !== mChg[0]) begin
      tests_failed++; $display("FAIL w1c_stable: got %b expected %b", chgA, mChg[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, d;
    int lat;
    d = $urandom;
    do_access(1, 1'b1, BASE, d, rd, lat);
    mPort[1] = d;
    tests_run++;
    if (lat !== exp_lat(1) || poutB !== mPort[1]) begin
      tests_failed++;
      $display("FAIL b2b_sw: lat=%0d pout=%h expected %0d %h", lat, poutB, exp_lat(1), mPort[1]);
    end
    do_access(1, 1'b0, BASE, 32'd0, rd, lat);
    mRd[1] = mPort[1];
    tests_run++;
    if (lat !== exp_lat(1) || rd !== mRd[1]) begin
      tests_failed++;
      $display("FAIL b2b_lw: lat=%0d rd=%h expected %0d %h", lat, rd, exp_lat(1), mRd[1]);
    end
  endtask

  task automatic test_reset_mid;
    bit sawAck;
    drive(0, 1'b1, 1'b1, BASE, 32'h1234_5678);
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    mPort[0] = 32'd0; mPort[1] = 32'd0; mChg[0] = 1'b0; mRd[0] = 32'd0;
    tests_run++;
    if (ackA !== 1'b0 || poutA !== mPort[0] || chgA !== mChg[0] || rdA !== mRd[0] || poutB !== mPort[1]) begin
      tests_failed++;
      $display("FAIL async_reset: ack=%b pout=%h chg=%b rd=%h poutB=%h expected all 0",
               ackA, poutA, chgA, rdA, poutB);
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sawAck = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ackA === 1'b1) sawAck = 1;
    end
    tests_run++;
    if (sawAck || poutA !== mPort[0]) begin
      tests_failed++;
      $display("FAIL post_reset: ack_seen=%0d pout=%h expected 0 %h", sawAck, poutA, mPort[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mPort[i] = 32'd0; mChg[i] = 1'b0; mPin[i] = 32'd0; mRd[i] = 32'd0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    @(posedge clk); #1;
    test_write_read;
    test_port_in;
    test_random_access;
    test_miss;
    test_abort;
    test_set_wins;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
